// File: rtl/microwave_pkg.sv
// ----------------------------------------------------------------------------
// microwave_pkg
// Shared definitions for the microwave oven controller.
//   STATE_W  : width of the state code driven on the display port
//   state_t  : controller state encoding (IDLE=0, COOK=1, PAUSE=2, DONE=3)
// ----------------------------------------------------------------------------
package microwave_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_COOK  = 3'd1,
        S_PAUSE = 3'd2,
        S_DONE  = 3'd3
    } state_t;

endpackage

// File: rtl/edge_detect.sv
// ----------------------------------------------------------------------------
// edge_detect
// Rising-edge detector for one debounced button level.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  asynchronous active-high reset (clears the history register)
//   level in  debounced button level
//   rise  out level & !previous level (combinational, valid for this cycle)
// ----------------------------------------------------------------------------
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    // A held button produces exactly one rise; it re-arms only after level
    // has been seen low for at least one cycle.
    assign rise = level & ~level_q;

endmodule

// File: rtl/microwave_ctrl.sv
// ----------------------------------------------------------------------------
// microwave_ctrl
// Moore controller for a microwave oven: IDLE / COOK / PAUSE / DONE.
// All outputs are registers loaded from the decode of the next state, so they
// change on the same clock edge as the state itself and drop asynchronously
// with rst.
//
// Optional feature macro: MICROWAVE_CTRL_BEEP_EN
//   defined   : DONE lasts BEEP_CYCLES cycles with beep high (stop cuts it short)
//   undefined : DONE lasts one cycle, no beep counter, beep tied low
//
// Parameters:
//   BEEP_CYCLES  beeper duration in DONE, 1..15
//   BEEP_W       beep counter width, >= clog2(BEEP_CYCLES+1)
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   start_db     in   debounced start button level
//   stop_db      in   debounced stop/cancel button level
//   door_closed  in   door switch, 1 = closed
//   timer_zero   in   countdown timer reads 00:00
//   magnetron_on out  heating enable (COOK only)
//   timer_enable out  timer may count down (COOK only)
//   timer_clear  out  one-cycle pulse that zeroes the timer
//   beep         out  done beeper
//   state        out  current state code for display
// ----------------------------------------------------------------------------
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int BEEP_CYCLES = 8,
    parameter int BEEP_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_db,
    input  logic               stop_db,
    input  logic               door_closed,
    input  logic               timer_zero,
    output logic               magnetron_on,
    output logic               timer_enable,
    output logic               timer_clear,
    output logic               beep,
    output logic [STATE_W-1:0] state
);

    state_t state_q;
    state_t state_d;
    logic   start_edge;
    logic   stop_edge;

    // Next values of the registered outputs.
    logic   magnetron_d;
    logic   clear_d;
    logic   beep_d;

    edge_detect u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .level (start_db),
        .rise  (start_edge)
    );

    edge_detect u_stop_edge (
        .clk   (clk),
        .rst   (rst),
        .level (stop_db),
        .rise  (stop_edge)
    );

    // A start request is honoured only with the door shut and time remaining.
    logic start_ok;
    assign start_ok = start_edge & door_closed & ~timer_zero;

`ifdef MICROWAVE_CTRL_BEEP_EN
    logic [BEEP_W-1:0] beep_cnt;
    logic              beep_last;
    assign beep_last = (beep_cnt <= BEEP_W'(1));
`endif

    // ------------------------------------------------------------------
    // State register and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            magnetron_on <= 1'b0;
            timer_enable <= 1'b0;
            timer_clear  <= 1'b0;
            beep         <= 1'b0;
        end else begin
            state_q      <= state_d;
            magnetron_on <= magnetron_d;
            timer_enable <= magnetron_d;
            timer_clear  <= clear_d;
            beep         <= beep_d;
        end
    end

`ifdef MICROWAVE_CTRL_BEEP_EN
    // Loaded on entry to DONE, counts down while DONE is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep_cnt <= '0;
        end else if (state_d == S_DONE && state_q != S_DONE) begin
            beep_cnt <= BEEP_W'(BEEP_CYCLES);
        end else if (state_q == S_DONE && beep_cnt != '0) begin
            beep_cnt <= beep_cnt - BEEP_W'(1);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // Stop wins over a simultaneous start.
                if (stop_edge) begin
                    state_d = S_IDLE;
                end else if (start_ok) begin
                    state_d = S_COOK;
                end
            end
            S_COOK: begin
                // Door open has top priority so heating can never outlive it.
                if (!door_closed) begin
                    state_d = S_PAUSE;
                end else if (timer_zero) begin
                    state_d = S_DONE;
                end else if (stop_edge) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (stop_edge) begin
                    state_d = S_IDLE;
                end else if (timer_zero) begin
                    state_d = S_IDLE;
                end else if (start_ok) begin
                    state_d = S_COOK;
                end
            end
            S_DONE: begin
`ifdef MICROWAVE_CTRL_BEEP_EN
                if (stop_edge || beep_last) begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (from the next state, registered above)
    // ------------------------------------------------------------------
    always_comb begin
        magnetron_d = 1'b0;
        clear_d     = 1'b0;
        beep_d      = 1'b0;
        if (state_d == S_COOK) begin
            magnetron_d = 1'b1;
        end
`ifdef MICROWAVE_CTRL_BEEP_EN
        if (state_d == S_DONE) begin
            beep_d = 1'b1;
        end
`endif
        // Cancel from IDLE or PAUSE zeroes the timer.
        if (stop_edge && (state_q == S_IDLE || state_q == S_PAUSE)) begin
            clear_d = 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
module tb_microwave_ctrl;

    logic       clk;
    logic       rst;
    logic       start_db;
    logic       stop_db;
    logic       door_closed;
    logic       timer_zero;
    logic       magnetron_on;
    logic       timer_enable;
    logic       timer_clear;
    logic       beep;
    logic [2:0] state;

    int total;
    int bad;

    microwave_ctrl #(.BEEP_CYCLES(8), .BEEP_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_db     (start_db),
        .stop_db      (stop_db),
        .door_closed  (door_closed),
        .timer_zero   (timer_zero),
        .magnetron_on (magnetron_on),
        .timer_enable (timer_enable),
        .timer_clear  (timer_clear),
        .beep         (beep),
        .state        (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; inputs driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        start_db = 1'b1;
        tick();
        start_db = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start_db = 0; stop_db = 0; door_closed = 1; timer_zero = 0;
        tick(); tick();
        total++;
        if (state !== 3'd0 || magnetron_on !== 0 || timer_enable !== 0 ||
            timer_clear !== 0 || beep !== 0) begin
            bad++;
            $display("FAIL reset_state: got st=%0d mag=%b en=%b clr=%b bp=%b want 0/0/0/0/0",
                     state, magnetron_on, timer_enable, timer_clear, beep);
        end
        @(negedge clk); rst = 1'b0;
        tick();
    endtask

    task automatic test_start_blocked();
        // Door open: start ignored.
        door_closed = 0;
        press_start(); tick();
        total++;
        if (state !== 3'd0 || magnetron_on !== 0) begin
            bad++; $display("FAIL start_door_open: got st=%0d mag=%b want 0/0", state, magnetron_on);
        end
        // Timer at zero: start ignored.
        door_closed = 1; timer_zero = 1;
        press_start(); tick();
        total++;
        if (state !== 3'd0) begin
            bad++; $display("FAIL start_timer_zero: got st=%0d want 0", state);
        end
        timer_zero = 0;
    endtask

    task automatic test_start();
        start_db = 1'b1;
        #2;
        total++;
        if (state !== 3'd0) begin
            bad++; $display("FAIL start_before_edge: got st=%0d want 0", state);
        end
        tick();
        start_db = 1'b0;
        total++;
        if (state !== 3'd1 || magnetron_on !== 1 || timer_enable !== 1) begin
            bad++; $display("FAIL start_cook: got st=%0d mag=%b en=%b want 1/1/1",
                            state, magnetron_on, timer_enable);
        end
        tick();
    endtask

    task automatic test_door();
        door_closed = 0;
        tick();
        total++;
        if (state !== 3'd2 || magnetron_on !== 0 || timer_enable !== 0) begin
            bad++; $display("FAIL door_open_pause: got st=%0d mag=%b en=%b want 2/0/0",
                            state, magnetron_on, timer_enable);
        end
        // Start with the door still open must not heat.
        press_start(); tick();
        total++;
        if (state !== 3'd2 || magnetron_on !== 0) begin
            bad++; $display("FAIL pause_start_door_open: got st=%0d mag=%b want 2/0", state, magnetron_on);
        end
        door_closed = 1;
        press_start();
        total++;
        if (state !== 3'd1 || magnetron_on !== 1) begin
            bad++; $display("FAIL resume_cook: got st=%0d mag=%b want 1/1", state, magnetron_on);
        end
        tick();
    endtask

    task automatic test_done();
        int done_cycles;
        int beep_cycles;
        int exp_done;
        int exp_beep;
`ifdef MICROWAVE_CTRL_BEEP_EN
        exp_done = 8; exp_beep = 8;
`else
        exp_done = 1; exp_beep = 0;
`endif
        done_cycles = 0; beep_cycles = 0;
        timer_zero = 1;
        tick();
        total++;
        if (state !== 3'd3 || magnetron_on !== 0) begin
            bad++; $display("FAIL cook_to_done: got st=%0d mag=%b want 3/0", state, magnetron_on);
        end
        while (state === 3'd3 && done_cycles < 30) begin
            done_cycles++;
            if (beep === 1'b1) beep_cycles++;
            tick();
        end
        total++;
        if (done_cycles != exp_done || beep_cycles != exp_beep) begin
            bad++; $display("FAIL done_length: got done=%0d beep=%0d want %0d/%0d",
                            done_cycles, beep_cycles, exp_done, exp_beep);
        end
        total++;
        if (state !== 3'd0 || beep !== 0) begin
            bad++; $display("FAIL done_to_idle: got st=%0d bp=%b want 0/0", state, beep);
        end
        timer_zero = 0;
        tick();
    endtask

    task automatic test_stop_pause();
        press_start();
        stop_db = 1; tick(); stop_db = 0;
        total++;
        if (state !== 3'd2 || timer_clear !== 0) begin
            bad++; $display("FAIL cook_stop_pause: got st=%0d clr=%b want 2/0", state, timer_clear);
        end
        tick();
        stop_db = 1; tick(); stop_db = 0;
        total++;
        if (state !== 3'd0 || timer_clear !== 1) begin
            bad++; $display("FAIL pause_stop_idle: got st=%0d clr=%b want 0/1", state, timer_clear);
        end
        tick();
        total++;
        if (timer_clear !== 0) begin
            bad++; $display("FAIL clear_width: got clr=%b want 0", timer_clear);
        end
    endtask

    task automatic test_simultaneous();
        start_db = 1; stop_db = 1;
        tick();
        total++;
        if (state !== 3'd0 || timer_clear !== 1) begin
            bad++; $display("FAIL start_stop_same: got st=%0d clr=%b want 0/1", state, timer_clear);
        end
        start_db = 0; stop_db = 0;
        tick();
        total++;
        if (state !== 3'd0 || timer_clear !== 0) begin
            bad++; $display("FAIL start_stop_after: got st=%0d clr=%b want 0/0", state, timer_clear);
        end
    endtask

    task automatic test_held_start();
        int entries;
        int cook_cycles;
        logic [2:0] prev;
        entries = 0; cook_cycles = 0;
        prev = state;
        start_db = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state === 3'd1 && prev !== 3'd1) entries++;
            if (state === 3'd1) cook_cycles++;
            prev = state;
        end
        total++;
        if (entries != 1 || cook_cycles != 20) begin
            bad++; $display("FAIL held_start: got entries=%0d cook=%0d want 1/20", entries, cook_cycles);
        end
        // Pause with start still held: no re-entry into COOK.
        stop_db = 1; tick(); stop_db = 0;
        tick(); tick();
        total++;
        if (state !== 3'd2) begin
            bad++; $display("FAIL held_start_no_rearm: got st=%0d want 2", state);
        end
        start_db = 0;
        tick();
        stop_db = 1; tick(); stop_db = 0;
        tick();
    endtask

    task automatic test_reset_cook();
        press_start();
        total++;
        if (state !== 3'd1) begin
            bad++; $display("FAIL precook: got st=%0d want 1", state);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (magnetron_on !== 0 || timer_enable !== 0 || state !== 3'd0) begin
            bad++; $display("FAIL async_reset: got mag=%b en=%b st=%0d want 0/0/0",
                            magnetron_on, timer_enable, state);
        end
        @(negedge clk); rst = 1'b0;
        tick();
        press_start();
        total++;
        if (state !== 3'd1) begin
            bad++; $display("FAIL post_reset_start: got st=%0d want 1", state);
        end
        stop_db = 1; tick(); stop_db = 0; tick();
        stop_db = 1; tick(); stop_db = 0; tick();
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_start_blocked();
        test_start();
        test_door();
        test_done();
        test_stop_pause();
        test_simultaneous();
        test_held_start();
        test_reset_cook();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
